// File: rtl/imm_extend_seq.sv
// imm_extend_seq: accumulates IN_W-bit fragments MSB-first and emits the
// zero/sign-extended OUT_W-bit immediate through a registered valid/ready port.
module imm_extend_seq #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  val,
  input  logic             in_signed,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_ovf
);

  localparam int unsigned MAX_FRAG = OUT_W / IN_W;
  localparam int unsigned CNT_W    = $clog2(MAX_FRAG + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               completing;
  logic [OUT_W-1:0]   acc_shift;
  logic [OUT_W-1:0]   width_mask;
  logic [OUT_W-1:0]   top_bit;
  logic [OUT_W-1:0]   ext;
  logic               sign_bit;
  int unsigned        width;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = !out_valid || out_ready;
  assign out       = out_q;
  assign out_ovf   = ovf_q;

  // Shift in the new fragment and build the extended result for its width.
  // Shifting by IN_W also covers OUT_W == IN_W: the old contents drop out.
  always_comb begin
    accept     = in_valid && in_ready;
    completing = accept && (in_last || (cnt_q == CNT_W'(MAX_FRAG - 1)));
    acc_shift  = (acc_q << IN_W) | OUT_W'(val);
    width      = (32'(cnt_q) + 32'd1) * IN_W;
    width_mask = ~({OUT_W{1'b1}} << width);
    top_bit    = width_mask ^ (width_mask >> 1);
    sign_bit   = |(acc_shift & top_bit);
    ext        = (in_signed && sign_bit) ? (acc_shift | ~width_mask)
                                         : (acc_shift & width_mask);
  end

  // Next-state logic: completing accept loads the result register, drain
  // returns to IDLE/ACCUM depending on whether a new word has started.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    if (completing) begin
      acc_d   = '0;
      cnt_d   = '0;
      out_d   = ext;
      ovf_d   = !in_last;
      state_d = HOLD;
    end else begin
      if (accept) begin
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q != HOLD || out_ready) begin
        state_d = (cnt_d != '0) ? ACCUM : IDLE;
      end
    end
  end

  // State, accumulator and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_seq.sv
// Bench for imm_extend_seq: fragment-queue model checked every cycle,
// plus directed scenarios with literal expectations (including OUT_W=32).
module tb_imm_extend_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, in_last;
  logic [7:0]  val;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out;

  logic        b_in_valid, b_in_ready, b_in_signed, b_in_last;
  logic [7:0]  b_val;
  logic        b_out_valid, b_out_ready, b_out_ovf;
  logic [31:0] b_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extend_seq #(.IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .val(val), .in_signed(in_signed), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf)
  );

  imm_extend_seq #(.IN_W(8), .OUT_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .val(b_val), .in_signed(b_in_signed), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out), .out_ovf(b_out_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: collect fragments of the current word, assemble on completion.
  logic [7:0]  frags[$];
  bit          exp_valid;
  logic [15:0] exp_out;
  bit          exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frags.delete();
      exp_valid = 0;
      exp_out   = '0;
      exp_ovf   = 0;
    end else begin
      bit          took;
      bit          done;
      logic [63:0] v;
      int          w;
      took = in_valid && (!exp_valid || out_ready);
      done = 0;
      if (took) begin
        frags.push_back(val);
        if (in_last || frags.size() == 2) begin
          v = '0;
          foreach (frags[k]) v = (v << 8) | 64'(frags[k]);
          w = frags.size() * 8;
          if (in_signed && v[w-1]) v = v | ~((64'd1 << w) - 64'd1);
          exp_out   = v[15:0];
          exp_ovf   = !in_last;
          exp_valid = 1;
          frags.delete();
          done = 1;
        end
      end
      if (!done && out_ready) exp_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out",       32'(out),       32'(exp_out));
    chk("out_ovf",   32'(out_ovf),   32'(exp_ovf));
    chk("in_ready",  32'(in_ready),  32'(!exp_valid || out_ready));
  end

  // Present one fragment; returns 2ns after the edge that accepted it.
  task automatic send(input logic [7:0] v, input logic l, input logic s, output int waits);
    bit got;
    in_valid  = 1'b1;
    val       = v;
    in_last   = l;
    in_signed = s;
    got   = 0;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      #1 got = in_ready;
      @(posedge clk);
      #2;
      if (got) break;
      waits++;
    end
    if (!got) begin
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for fragment 0x%0h", v);
    end
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_result(input string nm, input logic [15:0] o, input logic ovf);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_out"},   32'(out),       32'(o));
    chk({nm, "_ovf"},   32'(out_ovf),   32'(ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] sv;
    rst_n = 1'b0; in_valid = 0; val = '0; in_signed = 0; in_last = 0; out_ready = 1;
    b_in_valid = 0; b_val = '0; b_in_signed = 0; b_in_last = 0; b_out_ready = 1;
    #22 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // OUT_W=32 two-fragment cases
    b_in_valid = 1; b_val = 8'h80; b_in_last = 0; b_in_signed = 0;
    @(posedge clk); #2;
    b_val = 8'h01; b_in_last = 1; b_in_signed = 1;
    @(posedge clk); #2;
    chk("w32_signed", b_out, 32'hFFFF8001);
    chk("w32_valid", 32'(b_out_valid), 32'd1);
    b_val = 8'h80; b_in_last = 0; b_in_signed = 0;
    @(posedge clk); #2;
    b_val = 8'h01; b_in_last = 1; b_in_signed = 0;
    @(posedge clk); #2;
    chk("w32_unsigned", b_out, 32'h00008001);
    chk("w32_ovf", 32'(b_out_ovf), 32'd0);
    b_in_valid = 0;

    // single fragment, all modes
    send(8'h8A, 1, 0, w); chk_result("s8A_z", 16'h008A, 0);
    send(8'h8A, 1, 1, w); chk_result("s8A_s", 16'hFF8A, 0);
    send(8'h0A, 1, 1, w); chk_result("s0A_s", 16'h000A, 0);
    send(8'h0A, 1, 0, w); chk_result("s0A_z", 16'h000A, 0);
    idle_cycle();
    chk("drained", 32'(out_valid), 32'd0);

    // two fragments MSB-first
    send(8'h92, 0, 0, w);
    send(8'h34, 1, 1, w); chk_result("two", 16'h9234, 0);

    // overflow force-completion
    send(8'h12, 0, 0, w);
    send(8'h34, 0, 0, w); chk_result("ovf", 16'h1234, 1);
    send(8'h56, 0, 0, w);
    send(8'h78, 1, 0, w); chk_result("after_ovf", 16'h5678, 0);
    idle_cycle();

    // backpressure
    out_ready = 0;
    send(8'h00, 0, 0, w);
    send(8'hAB, 1, 0, w); chk_result("bp", 16'h00AB, 0);
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_out", 32'(out), 32'h00AB);
    end
    out_ready = 1;
    send(8'hCD, 1, 1, w); chk_result("bp_release", 16'hFFCD, 0);
    idle_cycle();

    // streaming, no bubbles
    for (int i = 0; i < 8; i++) begin
      sv = 8'h80 + 8'(i);
      send(sv, 1, 1, w);
      chk("stream_waits", 32'(w), 32'd0);
      chk_result("stream", {8'hFF, sv}, 0);
    end
    idle_cycle();

    // reset mid-accumulation
    send(8'h7F, 0, 0, w);
    in_valid = 0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    send(8'h01, 1, 0, w); chk_result("post_rst", 16'h0001, 0);
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
